// File: rtl/pe_feeder_pkg.sv
// Shared motion-estimation definitions for the PE feeder.
//   ME_PIX_W      default pixel width
//   fsm_state_e   sequencer states (idle, current-block read, window read, drain)
//   phase_tag_e   tag carried alongside each outstanding buffer read
//   cnt_width()   counter width able to hold the larger of two run lengths
package pe_feeder_pkg;

    localparam int unsigned ME_PIX_W = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRdCrt = 2'd1,
        StRdPre = 2'd2,
        StDrain = 2'd3
    } fsm_state_e;

    typedef enum logic {
        TagCrt = 1'b0,
        TagPre = 1'b1
    } phase_tag_e;

    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned mx;
        mx = (a > b) ? a : b;
        return (mx < 1) ? 1 : $clog2(mx + 1);
    endfunction

endpackage

// File: rtl/pe_feed_addr_gen.sv
// Base-plus-offset read address generator.
//   clk, rst      clock / async active-high reset
//   load_i        restart at base_i with offset 0 (has priority over inc_i)
//   inc_i         advance address and offset by one
//   base_i        start address for the next load
//   last_i        offset value that marks the final read of the current run
//   addr_o        registered read address, wraps modulo 2^ADDR_W
//   tc_o          current offset equals last_i
module pe_feed_addr_gen #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned CNT_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [CNT_W-1:0]  last_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              tc_o
);

    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;

    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            addr_d = base_i;
            cnt_d  = '0;
        end else if (inc_i) begin
            // Natural overflow of the ADDR_W-bit add gives the modulo wrap.
            addr_d = addr_q + ADDR_W'(1);
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign addr_o = addr_q;
    assign tc_o   = (cnt_q == last_i);

endmodule

// File: rtl/pe_feeder.sv
// Sequencer feeding the motion-estimation PE chain. Each accepted start reads
// BLK_N current-block pixels from crt_base, then WIN_M window pixels from
// pre_base, back to back through a single-read-port buffer, and presents them
// to the chain head.
//   clk, rst                  clock / async active-high reset
//   start                     run request, sampled only while idle
//   crt_base, pre_base        run base addresses, captured with start
//   busy, done                run in progress / one-cycle end-of-run pulse
//   mem_rd_en, mem_rd_addr    buffer read strobe and address
//   mem_rd_data               read data, valid one cycle after mem_rd_en
//   crt_pixel_o               current-block pixel (shifted in while crt_keep_o=0)
//   pre_pixel_o, pre_valid_o  window pixel and its qualifier
//   crt_keep_o                1 = chain holds its block and computes AD
module pe_feeder
    import pe_feeder_pkg::*;
#(
    parameter int unsigned PIX_W  = ME_PIX_W,
    parameter int unsigned BLK_N  = 16,
    parameter int unsigned WIN_M  = 64,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] crt_base,
    input  logic [ADDR_W-1:0] pre_base,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [PIX_W-1:0]  mem_rd_data,
    output logic [PIX_W-1:0]  crt_pixel_o,
    output logic [PIX_W-1:0]  pre_pixel_o,
    output logic              crt_keep_o,
    output logic              pre_valid_o
);

    localparam int unsigned CNT_W = cnt_width(BLK_N, WIN_M);
    localparam logic [CNT_W-1:0] CrtLast = CNT_W'(BLK_N - 1);
    localparam logic [CNT_W-1:0] PreLast = CNT_W'(WIN_M - 1);

    fsm_state_e        state_d, state_q;
    logic              drain_d, drain_q;
    logic [ADDR_W-1:0] pre_base_d, pre_base_q;
    logic              busy_d, busy_q;
    logic              done_d, done_q;
    logic              rd_en_d, rd_en_q;
    logic              tag_vld_d, tag_vld_q;
    phase_tag_e        tag_d, tag_q;
    logic [PIX_W-1:0]  crt_pixel_d, crt_pixel_q;
    logic [PIX_W-1:0]  pre_pixel_d, pre_pixel_q;
    logic              keep_d, keep_q;
    logic              pre_valid_d, pre_valid_q;

    logic              ag_load, ag_inc, ag_tc;
    logic [ADDR_W-1:0] ag_base, ag_addr;
    logic [CNT_W-1:0]  ag_last;

    pe_feed_addr_gen #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .load_i (ag_load),
        .inc_i  (ag_inc),
        .base_i (ag_base),
        .last_i (ag_last),
        .addr_o (ag_addr),
        .tc_o   (ag_tc)
    );

    // Sequencer: next state and address-generator control.
    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        pre_base_d = pre_base_q;
        done_d     = 1'b0;
        ag_load    = 1'b0;
        ag_inc     = 1'b0;
        ag_base    = crt_base;
        ag_last    = CrtLast;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StRdCrt;
                    ag_load    = 1'b1;
                    ag_base    = crt_base;
                    pre_base_d = pre_base;
                end
            end
            StRdCrt: begin
                ag_last = CrtLast;
                if (ag_tc) begin
                    // Reload straight into the window run: no bubble.
                    state_d = StRdPre;
                    ag_load = 1'b1;
                    ag_base = pre_base_q;
                end else begin
                    ag_inc = 1'b1;
                end
            end
            StRdPre: begin
                ag_last = PreLast;
                if (ag_tc) begin
                    state_d = StDrain;
                    drain_d = 1'b0;
                end else begin
                    ag_inc = 1'b1;
                end
            end
            StDrain: begin
                // Two cycles cover the read latency plus the output register.
                if (drain_q) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Registered status and pixel outputs.
    always_comb begin
        busy_d      = (state_d != StIdle);
        rd_en_d     = (state_d == StRdCrt) || (state_d == StRdPre);
        tag_vld_d   = rd_en_q;
        tag_d       = (state_q == StRdPre) ? TagPre : TagCrt;
        crt_pixel_d = crt_pixel_q;
        pre_pixel_d = '0;
        pre_valid_d = 1'b0;
        keep_d      = 1'b1;
        if (tag_vld_q) begin
            if (tag_q == TagCrt) begin
                crt_pixel_d = mem_rd_data;
                keep_d      = 1'b0;
            end else begin
                pre_pixel_d = mem_rd_data;
                pre_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            drain_q     <= 1'b0;
            pre_base_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            tag_vld_q   <= 1'b0;
            tag_q       <= TagCrt;
            crt_pixel_q <= '0;
            pre_pixel_q <= '0;
            keep_q      <= 1'b1;
            pre_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            pre_base_q  <= pre_base_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            tag_vld_q   <= tag_vld_d;
            tag_q       <= tag_d;
            crt_pixel_q <= crt_pixel_d;
            pre_pixel_q <= pre_pixel_d;
            keep_q      <= keep_d;
            pre_valid_q <= pre_valid_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign mem_rd_en   = rd_en_q;
    assign mem_rd_addr = ag_addr;
    assign crt_pixel_o = crt_pixel_q;
    assign pre_pixel_o = pre_pixel_q;
    assign crt_keep_o  = keep_q;
    assign pre_valid_o = pre_valid_q;

endmodule

// File: tb/tb_pe_feeder.sv
// Directed bench for pe_feeder with a queue scoreboard and a cycle-position
// model of the control outputs. Buffer model: memory[a] = a[7:0].
module tb_pe_feeder;

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned BLK_N  = 4;
    localparam int unsigned WIN_M  = 8;
    localparam int unsigned ADDR_W = 12;
    localparam int RUN = BLK_N + WIN_M + 3;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] crt_base;
    logic [ADDR_W-1:0] pre_base;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [PIX_W-1:0]  mem_rd_data;
    logic [PIX_W-1:0]  crt_pixel_o;
    logic [PIX_W-1:0]  pre_pixel_o;
    logic              crt_keep_o;
    logic              pre_valid_o;

    int nvec = 0;
    int nerr = 0;

    logic [ADDR_W-1:0] addr_sb[$];
    logic [PIX_W-1:0]  crt_sb[$];
    logic [PIX_W-1:0]  pre_sb[$];
    logic [PIX_W-1:0]  last_crt;

    pe_feeder #(
        .PIX_W  (PIX_W),
        .BLK_N  (BLK_N),
        .WIN_M  (WIN_M),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .crt_base    (crt_base),
        .pre_base    (pre_base),
        .busy        (busy),
        .done        (done),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .crt_pixel_o (crt_pixel_o),
        .pre_pixel_o (pre_pixel_o),
        .crt_keep_o  (crt_keep_o),
        .pre_valid_o (pre_valid_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_ff @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_rd_addr[7:0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_done"}, {31'd0, done}, 0);
        chk({tag, "_rd_en"}, {31'd0, mem_rd_en}, 0);
        chk({tag, "_rd_addr"}, {20'd0, mem_rd_addr}, 0);
        chk({tag, "_crt_pixel"}, {24'd0, crt_pixel_o}, 0);
        chk({tag, "_pre_pixel"}, {24'd0, pre_pixel_o}, 0);
        chk({tag, "_keep"}, {31'd0, crt_keep_o}, 1);
        chk({tag, "_pre_valid"}, {31'd0, pre_valid_o}, 0);
    endtask

    task automatic push_run(input logic [ADDR_W-1:0] cb, input logic [ADDR_W-1:0] pb);
        logic [ADDR_W-1:0] a;
        for (int k = 0; k < int'(BLK_N); k++) begin
            a = cb + k[ADDR_W-1:0];
            addr_sb.push_back(a);
            crt_sb.push_back(a[7:0]);
        end
        for (int j = 0; j < int'(WIN_M); j++) begin
            a = pb + j[ADDR_W-1:0];
            addr_sb.push_back(a);
            pre_sb.push_back(a[7:0]);
        end
    endtask

    // c = cycle position within a run (cycle 0 = start edge); c <= 0 or > RUN means idle.
    task automatic check_cycle(input int c);
        logic [ADDR_W-1:0] ea;
        logic [PIX_W-1:0]  ep;
        chk("rd_en", {31'd0, mem_rd_en}, {31'd0, (c >= 1 && c <= int'(BLK_N + WIN_M))});
        chk("busy", {31'd0, busy}, {31'd0, (c >= 1 && c <= RUN - 1)});
        chk("done", {31'd0, done}, {31'd0, (c == RUN)});
        chk("keep", {31'd0, crt_keep_o}, {31'd0, !(c >= 3 && c <= int'(BLK_N) + 2)});
        chk("pre_valid", {31'd0, pre_valid_o},
            {31'd0, (c >= int'(BLK_N) + 3 && c <= RUN - 1)});
        if (mem_rd_en) begin
            chk("addr_pending", {31'd0, (addr_sb.size() > 0)}, 1);
            if (addr_sb.size() > 0) begin
                ea = addr_sb.pop_front();
                chk("rd_addr", {20'd0, mem_rd_addr}, {20'd0, ea});
            end
        end
        if (!crt_keep_o) begin
            chk("crt_pending", {31'd0, (crt_sb.size() > 0)}, 1);
            if (crt_sb.size() > 0) begin
                ep = crt_sb.pop_front();
                chk("crt_pixel", {24'd0, crt_pixel_o}, {24'd0, ep});
                last_crt = ep;
            end
        end else begin
            chk("crt_hold", {24'd0, crt_pixel_o}, {24'd0, last_crt});
        end
        if (pre_valid_o) begin
            chk("pre_pending", {31'd0, (pre_sb.size() > 0)}, 1);
            if (pre_sb.size() > 0) begin
                ep = pre_sb.pop_front();
                chk("pre_pixel", {24'd0, pre_pixel_o}, {24'd0, ep});
            end
        end else begin
            chk("pre_idle_zero", {24'd0, pre_pixel_o}, 0);
        end
    endtask

    // Caller is just after a negedge. Optionally re-pulses start at cycle rp_c.
    task automatic run_one(input logic [ADDR_W-1:0] cb, input logic [ADDR_W-1:0] pb,
                           input int rp_c);
        crt_base = cb;
        pre_base = pb;
        start    = 1'b1;
        push_run(cb, pb);
        for (int c = 1; c <= RUN + 2; c++) begin
            @(negedge clk);
            check_cycle(c);
            start = 1'b0;
            if (c == rp_c) begin
                start    = 1'b1;
                crt_base = 12'h300;
                pre_base = 12'h400;
            end
        end
        chk("sb_empty", addr_sb.size() + crt_sb.size() + pre_sb.size(), 0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        crt_base = '0;
        pre_base = '0;
        last_crt = '0;
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_cycle(0);
        end

        // Basic run.
        run_one(12'h010, 12'h100, -1);
        // Window address wrap.
        run_one(12'h7F0, 12'hFFC, -1);
        // Start re-pulsed while busy.
        run_one(12'h020, 12'h200, 5);

        // Back-to-back: start held through the first done cycle.
        crt_base = 12'h040;
        pre_base = 12'h500;
        start    = 1'b1;
        push_run(12'h040, 12'h500);
        for (int t = 1; t <= 2 * RUN + 2; t++) begin
            @(negedge clk);
            check_cycle((t <= RUN) ? t : t - RUN);
            if (t == RUN) push_run(12'h040, 12'h500);
            if (t == 2 * RUN) start = 1'b0;
        end
        chk("b2b_sb_empty", addr_sb.size() + crt_sb.size() + pre_sb.size(), 0);

        // Async reset mid-run in cycle 9.
        crt_base = 12'h060;
        pre_base = 12'h600;
        start    = 1'b1;
        push_run(12'h060, 12'h600);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            check_cycle(c);
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        addr_sb.delete();
        crt_sb.delete();
        pre_sb.delete();
        last_crt = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_cycle(0);
        end
        run_one(12'h080, 12'h700, -1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pe_feeder.md
# pe_feeder

Sequencer that feeds the motion-estimation PE chain. On each `start` it reads one current-frame block of `BLK_N` pixels from `crt_base`, then one search-window run of `WIN_M` pixels from `pre_base`, through a shared single-read-port pixel buffer. It presents the pixels on the PE chain's input pins: `crt_pixel_o`, `pre_pixel_o` and `crt_keep_o`.

## Interface
Parameters:
- `PIX_W`, 8, pixel width.
- `BLK_N`, 16, current-block pixels shifted into the chain (≥1).
- `WIN_M`, 64, search-window pixels streamed per run (≥1).
- `ADDR_W`, 12, buffer address width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  run request; sampled only in IDLE.
- `crt_base`  in  ADDR_W  current-block start address; captured with `start`.
- `pre_base`  in  ADDR_W  search-window start address; captured with `start`.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle end-of-run pulse.
- `mem_rd_en`  out  1  buffer read strobe.
- `mem_rd_addr`  out  ADDR_W  buffer read address.
- `mem_rd_data`  in  PIX_W  read data. Valid exactly one cycle after `mem_rd_en`.
- `crt_pixel_o`  out  PIX_W  current-block pixel to chain head.
- `pre_pixel_o`  out  PIX_W  search-window pixel to chain head.
- `crt_keep_o`  out  1  0 = chain shifts current pixels; 1 = hold block and compute AD.
- `pre_valid_o`  out  1  `pre_pixel_o` carries window data.

## Operation
- FSM states:
  - IDLE: on `start`=1 → RD_CRT.
  - RD_CRT: after `BLK_N` reads → RD_PRE.
  - RD_PRE: after `WIN_M` reads → DRAIN.
  - DRAIN: after 2 cycles → IDLE, with the `done` pulse issued on entry to IDLE.
- Read addresses:
  - RD_CRT issues `crt_base+k`, k=0..BLK_N-1, one per cycle.
  - RD_PRE issues `pre_base+j`, j=0..WIN_M-1, one per cycle.
  - No bubbles between or inside the two runs.
  - Addresses wrap modulo 2^ADDR_W.
- `mem_rd_data` is tagged CRT/PRE by a 1-cycle-delayed phase register.
- CRT-tagged data is registered into `crt_pixel_o` with `crt_keep_o`=0.
- PRE-tagged data is registered into `pre_pixel_o` with `pre_valid_o`=1 and `crt_keep_o`=1.
- When not presenting data:
  - `crt_keep_o`=1, so the loaded block is held.
  - `pre_pixel_o`=0 and `pre_valid_o`=0.
  - `crt_pixel_o` holds its last value.
- `start` while `busy`=1 is ignored. Base addresses are not re-captured.
- Counters are sized to hold `BLK_N` and `WIN_M` and never wrap within a run.
- Reset values: `busy`=0, `done`=0, `mem_rd_en`=0, `mem_rd_addr`=0, `crt_pixel_o`=0, `pre_pixel_o`=0, `crt_keep_o`=1, `pre_valid_o`=0. FSM in IDLE.
- Reset mid-run aborts immediately: all outputs go to their reset values, no `done` is issued, and partial state is discarded.

## Timing
- Cycle 0 is the edge at which `start`=1 is sampled in IDLE. N=`BLK_N`, M=`WIN_M`.
- `mem_rd_en`=1 in cycles 1..N+M.
  - Cycles 1..N carry CRT addresses.
  - Cycles N+1..N+M carry PRE addresses.
- Current pixel k appears on `crt_pixel_o` in cycle 3+k with `crt_keep_o`=0.
- `crt_keep_o` returns to 1 in cycle N+3.
- Window pixel j appears on `pre_pixel_o` in cycle N+3+j, with `pre_valid_o`=1 and `crt_keep_o`=1.
- `busy`=1 in cycles 1..N+M+2.
- `done`=1 only in cycle N+M+3, with `busy`=0.
- A `start` sampled in cycle N+M+3 is accepted, so back-to-back runs have zero idle gap.
- Latency from `start` to first chain pixel is 3 cycles. A full run takes N+M+3 cycles.
- All outputs are registered. No combinational path from any input to any output.

## Structure
- Shared ME package/header holds:
  - `PIX_W`
  - FSM state encodings (IDLE, RD_CRT, RD_PRE, DRAIN)
  - phase-tag constants (CRT/PRE)
- One sub-module, `pe_feed_addr_gen`, is natural. It is the base-plus-offset counter with load, increment, terminal-count flag and modulo-2^ADDR_W wrap, instantiated once and reloaded per phase.
- FSM, phase tag and output registers stay in `pe_feeder`.

## Test plan
- **Basic run.** N=4, M=8, `crt_base`=0x010, `pre_base`=0x100, memory[a]=a[7:0], `start` pulse.
  - Addresses 0x010–0x013 then 0x100–0x107 in cycles 1–12.
  - `crt_pixel_o` 0x10–0x13 in cycles 3–6 with `crt_keep_o`=0.
  - `pre_pixel_o` 0x00–0x07 in cycles 7–14 with `pre_valid_o`=1.
  - `done` only in cycle 15.
- **Address wrap.** `pre_base`=0xFFC, ADDR_W=12, M=8.
  - Addresses 0xFFC, 0xFFD, 0xFFE, 0xFFF, 0x000, 0x001, 0x002, 0x003.
- **Start while busy.** `start` re-pulsed in cycle 5 with different bases.
  - No change to the address sequence or `done` timing.
  - Exactly one `done`.
- **Back-to-back.** `start` held high continuously.
  - Second run issues its first read in cycle 16.
  - `done` in cycles 15 and 30.
- **Async reset mid-run.** `rst` asserted between edges in cycle 9.
  - All outputs at reset values immediately, with `crt_keep_o`=1.
  - No `done`.
  - A subsequent `start` runs cleanly from cycle 0 timing.
